// File: rtl/nouveau_busif.sv
// 68000 bus front end for the SDRAM controller: synchronises AS, decodes the
// fast-RAM window, issues ACCESS and turns VALID/WTERM completions into DTACK/BERR.
module nouveau_busif #(
  parameter logic [2:0] BASE    = 3'd1,
  parameter logic [2:0] TOP     = 3'd4,
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic [23:1] A,
  input  logic        VALID,
  input  logic        WTERM,
  output logic        ACCESS,
  output logic        DTACK,
  output logic        BERR,
  output logic        BUF_OE,
  output logic        BUF_DIR
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_ERR, S_SKIP, S_END} state_t;

  state_t     state, state_nxt;
  logic       as_meta_p0, as_s_p1;
  logic       sync_vld_p0, sync_vld_p1;
  logic       armed;
  logic       rw_l;
  logic [7:0] cnt;
  logic       hit, timeout_hit, done;
  logic       access_nxt, dtack_nxt, berr_nxt, buf_oe_nxt, buf_dir_nxt;

  // The controller holds a write until a strobe arrives, so the strobes and
  // low address bits never influence the request itself.
  logic       unused_inputs;
  assign unused_inputs = ^{UDS, LDS, A[20:1]};

  assign hit         = (A[23:21] >= BASE) && (A[23:21] <= TOP);
  assign timeout_hit = ({1'b0, cnt} + 9'd1) >= {1'b0, TIMEOUT};
  assign done        = rw_l ? ~VALID : ~WTERM;

  // Stage p0/p1: AS synchroniser. sync_vld marks when as_s_p1 holds a real
  // sample, so the reset value of the flops can never arm a partial cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      as_meta_p0  <= 1'b1;
      as_s_p1     <= 1'b1;
      sync_vld_p0 <= 1'b0;
      sync_vld_p1 <= 1'b0;
    end else begin
      as_meta_p0  <= AS;
      as_s_p1     <= as_meta_p0;
      sync_vld_p0 <= 1'b1;
      sync_vld_p1 <= sync_vld_p0;
    end
  end

  // State register, timeout counter, arming flag and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      armed   <= 1'b0;
      ACCESS  <= 1'b1;
      DTACK   <= 1'b1;
      BERR    <= 1'b1;
      BUF_OE  <= 1'b1;
      BUF_DIR <= 1'b1;
    end else begin
      state   <= state_nxt;
      armed   <= armed | (as_s_p1 & sync_vld_p1);
      if (state == S_IDLE)
        cnt <= '0;
      else if (state == S_REQ && cnt != 8'hFF)
        cnt <= cnt + 8'd1;
      ACCESS  <= access_nxt;
      DTACK   <= dtack_nxt;
      BERR    <= berr_nxt;
      BUF_OE  <= buf_oe_nxt;
      BUF_DIR <= buf_dir_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (state == S_IDLE && state_nxt == S_REQ)
      rw_l <= RW;
  end

  // Abort beats completion, completion beats timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!as_s_p1) state_nxt = (armed && hit) ? S_REQ : S_SKIP;
      S_REQ: begin
        if (as_s_p1)          state_nxt = S_END;
        else if (done)        state_nxt = S_ACK;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_ACK:  if (as_s_p1) state_nxt = S_END;
      S_ERR:  if (as_s_p1) state_nxt = S_END;
      S_SKIP: if (as_s_p1) state_nxt = S_IDLE;
      S_END:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    access_nxt  = ~(state_nxt == S_REQ || state_nxt == S_ACK);
    dtack_nxt   = ~(state_nxt == S_ACK);
    berr_nxt    = ~(state_nxt == S_ERR);
    buf_oe_nxt  = ~((state_nxt == S_REQ && state == S_REQ) || state_nxt == S_ACK);
    buf_dir_nxt = 1'b1;
    if (state_nxt == S_REQ || state_nxt == S_ACK || state_nxt == S_ERR)
      buf_dir_nxt = (state == S_IDLE) ? RW : rw_l;
  end

endmodule
